// File: rtl/sum_serial_tx.sv
// Adds two operands on a start request and shifts the {carry, sum} result out
// MSB-first over a chip-select / serial-clock / data link.
module sum_serial_tx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CLKDIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH:0]   result_o,
  output logic             cs_o,
  output logic             sclk_o,
  output logic             sdata_o
);

  localparam int unsigned          BIT_W    = $clog2(WIDTH + 1);
  localparam logic [7:0]           DIV_LAST = 8'(CLKDIV - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(WIDTH);
  localparam logic [BIT_W-1:0]     BIT_ONE  = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH:0]   shreg_q, shreg_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic [WIDTH:0]   sum;

  // Zero-extend before adding so the carry lands in the top bit.
  assign sum = {1'b0, a_i} + {1'b0, b_i};

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        if (start_i) begin
          state_d  = SHIFT;
          result_d = sum;
          sdata_d  = sum[WIDTH];
          shreg_d  = sum << 1;
          cs_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            // Last bit's high phase is over: drop into the chip-select hold.
            state_d = HOLD;
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
          end else begin
            bit_d   = bit_q + BIT_ONE;
            sclk_d  = 1'b0;
            sdata_d = shreg_q[WIDTH];
            shreg_d = shreg_q << 1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      HOLD: begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cs_d    = 1'b1;
        div_d   = '0;
        bit_d   = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cs_o     = cs_q;
  assign sclk_o   = sclk_q;
  assign sdata_o  = sdata_q;

endmodule

// File: tb/tb_sum_serial_tx.sv
// Directed bench for sum_serial_tx: default divider instance plus a CLKDIV=1
// instance, frames checked bit by bit against hand-computed sums.
module tb_sum_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       start0, start1;
  logic       sel;

  logic       busy0, done0, cs0, sclk0, sdata0;
  logic [8:0] result0;
  logic       busy1, done1, cs1, sclk1, sdata1;
  logic [8:0] result1;

  logic       busy_m, done_m, cs_m, sclk_m, sdata_m;
  logic [8:0] result_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sum_serial_tx #(.WIDTH(8), .CLKDIV(4)) dut (
    .clk(clk), .rst(rst), .a_i(a), .b_i(b), .start_i(start0),
    .busy_o(busy0), .done_o(done0), .result_o(result0),
    .cs_o(cs0), .sclk_o(sclk0), .sdata_o(sdata0)
  );

  sum_serial_tx #(.WIDTH(8), .CLKDIV(1)) dut_div1 (
    .clk(clk), .rst(rst), .a_i(a), .b_i(b), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .result_o(result1),
    .cs_o(cs1), .sclk_o(sclk1), .sdata_o(sdata1)
  );

  always_comb begin
    busy_m   = sel ? busy1   : busy0;
    done_m   = sel ? done1   : done0;
    cs_m     = sel ? cs1     : cs0;
    sclk_m   = sel ? sclk1   : sclk0;
    sdata_m  = sel ? sdata1  : sdata0;
    result_m = sel ? result1 : result0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller raises start; the first step is the accept edge (cycle 0), after
  // which the observed values are cycle 1. Returns in the DONE cycle.
  task automatic frame(input string tag, input logic [8:0] exp, input int exp_done,
                       input bit hold_start, input int chg_cyc, input logic [7:0] new_a,
                       input logic [7:0] new_b, input bit pulse_start);
    int         cyc, rises, done_cyc, cs_hi;
    logic [8:0] bits;
    logic       prev_sclk;
    step();
    cyc = 1;
    if (!hold_start) begin
      start0 = 1'b0;
      start1 = 1'b0;
    end
    check({tag, " c1 busy"}, 32'(busy_m), 32'd1);
    check({tag, " c1 cs"}, 32'(cs_m), 32'd0);
    check({tag, " c1 sclk"}, 32'(sclk_m), 32'd0);
    check({tag, " c1 sdata"}, 32'(sdata_m), 32'(exp[8]));
    check({tag, " c1 result"}, 32'(result_m), 32'(exp));
    prev_sclk = sclk_m;
    rises = 0;
    bits = '0;
    done_cyc = -1;
    cs_hi = 0;
    while (done_cyc < 0 && cyc < exp_done + 20) begin
      if (cyc == chg_cyc) begin
        a = new_a;
        b = new_b;
        if (pulse_start) start0 = 1'b1;
      end else if (pulse_start && cyc == chg_cyc + 1) begin
        start0 = 1'b0;
      end
      step();
      cyc++;
      if (sclk_m && !prev_sclk && !cs_m) begin
        rises++;
        bits = {bits[7:0], sdata_m};
      end
      prev_sclk = sclk_m;
      if (cs_m && !done_m) cs_hi++;
      if (done_m) done_cyc = cyc;
      if (cyc == exp_done - 1) begin
        check({tag, " hold cs"}, 32'(cs_m), 32'd0);
        check({tag, " hold sclk"}, 32'(sclk_m), 32'd0);
        check({tag, " hold sdata"}, 32'(sdata_m), 32'd0);
      end
    end
    check({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    check({tag, " rises"}, 32'(rises), 32'd9);
    check({tag, " bits"}, 32'(bits), 32'(exp));
    check({tag, " cs high mid-frame"}, 32'(cs_hi), 32'd0);
    check({tag, " done busy"}, 32'(busy_m), 32'd0);
    check({tag, " done cs"}, 32'(cs_m), 32'd1);
    check({tag, " done result"}, 32'(result_m), 32'(exp));
  endtask

  initial begin
    int dcount;
    rst = 1'b1;
    a = '0;
    b = '0;
    start0 = 1'b0;
    start1 = 1'b0;
    sel = 1'b0;
    step();
    step();
    check("rst cs", 32'(cs0), 32'd1);
    check("rst sclk", 32'(sclk0), 32'd0);
    check("rst sdata", 32'(sdata0), 32'd0);
    check("rst busy", 32'(busy0), 32'd0);
    check("rst done", 32'(done0), 32'd0);
    check("rst result", 32'(result0), 32'd0);
    rst = 1'b0;
    step();

    // 200 + 100 = 300 = 9'h12C
    a = 8'd200; b = 8'd100; start0 = 1'b1;
    frame("basic", 9'h12C, 74, 1'b0, 0, 8'd0, 8'd0, 1'b0);
    step();
    check("basic after done", 32'(done0), 32'd0);

    // 255 + 255 = 510 = 9'h1FE, carry goes out first
    a = 8'd255; b = 8'd255; start0 = 1'b1;
    frame("carry", 9'h1FE, 74, 1'b0, 0, 8'd0, 8'd0, 1'b0);
    step();

    // start held high: operands changed mid-frame only affect the next frame
    a = 8'd3; b = 8'd4; start0 = 1'b1;
    frame("b2b_1", 9'h007, 74, 1'b1, 40, 8'hAA, 8'h55, 1'b0);
    frame("b2b_2", 9'h0FF, 74, 1'b0, 0, 8'd0, 8'd0, 1'b0);
    step();

    // start pulse at cycle 20 with other operands is ignored
    a = 8'd200; b = 8'd100; start0 = 1'b1;
    frame("ignore", 9'h12C, 74, 1'b0, 20, 8'h0F, 8'h01, 1'b0);
    step();
    step();
    a = 8'd200; b = 8'd100; start0 = 1'b1;
    frame("glitch", 9'h12C, 74, 1'b0, 20, 8'h0F, 8'h01, 1'b1);
    step();
    check("glitch no queue busy", 32'(busy0), 32'd0);
    check("glitch no queue done", 32'(done0), 32'd0);
    check("glitch result kept", 32'(result0), 32'h12C);

    // reset in the middle of a frame
    a = 8'd200; b = 8'd100; start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (29) step();
    rst = 1'b1;
    #1;
    check("midrst cs", 32'(cs0), 32'd1);
    check("midrst sclk", 32'(sclk0), 32'd0);
    check("midrst sdata", 32'(sdata0), 32'd0);
    check("midrst busy", 32'(busy0), 32'd0);
    check("midrst result", 32'(result0), 32'd0);
    step();
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done0 || busy0) dcount++;
    end
    check("midrst no resume", 32'(dcount), 32'd0);
    a = 8'd255; b = 8'd255; start0 = 1'b1;
    frame("after rst", 9'h1FE, 74, 1'b0, 0, 8'd0, 8'd0, 1'b0);
    step();

    // CLKDIV=1 instance: 1 + 0 = 1, N=18, done at 20
    sel = 1'b1;
    a = 8'd1; b = 8'd0; start1 = 1'b1;
    frame("div1", 9'h001, 20, 1'b0, 0, 8'd0, 8'd0, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_serial_tx.md
# sum_serial_tx

Bit-serial transmitter for the tile's adder result. It latches two operands on a start request and forms their full-width sum, including carry. It then shifts the sum out MSB-first over a three-wire synchronous link (chip-select, clock, data) toward an off-chip receiver or logic analyser. It sits behind the tile's dedicated inputs and drives three bidirectional pins configured as outputs.

## Interface

- WIDTH, 8: operand width; frame length is WIDTH+1 bits.
- CLKDIV, 4: system clocks per serial-clock half-period; legal range 1..255.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_i  in  WIDTH  operand A; sampled only on an accepted start.
- b_i  in  WIDTH  operand B; sampled only on an accepted start.
- start_i  in  1  request to add and transmit; accepted when busy_o=0.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse marking frame completion.
- result_o  out  WIDTH+1  latched sum {carry, sum}; held until the next accepted start.
- cs_o  out  1  frame select, active-low.
- sclk_o  out  1  serial clock, idle low.
- sdata_o  out  1  serial data, MSB first.

## Operation

- Reset, asynchronous, effective immediately at any point including mid-frame: busy_o=0, done_o=0, cs_o=1, sclk_o=0, sdata_o=0, result_o=0, state IDLE, counters cleared. No partial frame resumes.
- States: IDLE, SHIFT, HOLD, DONE.
- IDLE: cs_o=1, sclk_o=0, sdata_o=0. start_i=1 is accepted. It latches result_o = a_i + b_i, zero-extended to WIDTH+1 bits so no overflow is lost. It loads the shift register with that value and moves to SHIFT.
- SHIFT: cs_o=0 and busy_o=1. Each bit period is 2*CLKDIV cycles: CLKDIV cycles with sclk_o=0, then CLKDIV cycles with sclk_o=1. sdata_o changes only at the start of a low phase and is stable across the rising edge of sclk_o. After bit 0's high phase ends, go to HOLD.
- HOLD: one cycle with cs_o=0, sclk_o=0, sdata_o=0 (chip-select hold), then DONE.
- DONE: one cycle with done_o=1, busy_o=0, cs_o=1. It behaves as IDLE for start acceptance. start_i=1 here is accepted and the next frame begins the following cycle; otherwise go to IDLE.
- start_i while busy_o=1 is ignored. It is not queued, and result_o is unaffected.
- Operand changes outside the accept cycle have no effect on the frame in flight.

## Timing

- Cycle 0 is the edge where start is accepted. Cycle 1 is the first SHIFT cycle: cs_o=0, sclk_o=0, sdata_o=result[WIDTH], busy_o=1, result_o valid.
- Let N = (WIDTH+1)*2*CLKDIV. SHIFT spans cycles 1..N. Bit k (from MSB, k=0..WIDTH) drives sdata_o during cycles 1+2k*CLKDIV .. (2k+2)*CLKDIV. sclk_o is high during the second half of each bit.
- HOLD is cycle N+1. DONE is cycle N+2 (done_o=1, cs_o=1, busy_o=0).
- Defaults (WIDTH=8, CLKDIV=4): N=72, HOLD at 73, done_o at 74. Back-to-back frames are separated by exactly one cs_o-high cycle.
- Outputs are registered; no combinational path from inputs to outputs.
- Bit counter and divider counter wrap only via state transitions; no free-running wrap.

## Test plan

- a=200, b=100, start pulse, defaults -> result_o=9'h12C. Bits sampled on sclk_o rising edges are 1,0,0,1,0,1,1,0,0. done_o pulses at cycle 74.
- a=255, b=255 -> result_o=9'h1FE. Carry is transmitted first; bits are 1,1,1,1,1,1,1,1,0. Exactly 9 sclk_o rising edges while cs_o=0.
- start_i held high continuously from cycle 0 -> a new frame starts at cycle 75. cs_o is high only in cycle 74. Operands are resampled at cycle 74.
- start_i pulsed at cycle 20 with a different a/b -> ignored. result_o and serial bits are unchanged, and done_o occurs at cycle 74 only.
- rst asserted at cycle 30 mid-frame -> immediately cs_o=1, sclk_o=0, sdata_o=0, busy_o=0, result_o=0. No done_o pulse. A fresh start after release produces a full, correct frame.
- CLKDIV=1, a=1, b=0 -> sclk_o toggles every cycle. Bits are 0,0,0,0,0,0,0,0,1. done_o at cycle 20.
